// File: rtl/program_loader.sv
// Nibble-serial program loader: assembles 3 strobed nibbles into one instruction
// word and writes it to a register-file program store that the CPU reads by pc.
module program_loader #(
    parameter int ADDR_BITS = 3,
    parameter int WORD_BITS = 9
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_mode,
    input  logic                 strobe,
    input  logic [3:0]           nibble,
    input  logic [ADDR_BITS-1:0] pc,
    output logic [WORD_BITS-1:0] statement,
    output logic                 cpu_hold,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [1:0]           phase,
    output logic                 word_written,
    output logic                 prog_full,
    output logic                 format_err
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    localparam logic [1:0] PH_HI  = 2'd0;
    localparam logic [1:0] PH_MID = 2'd1;
    localparam logic [1:0] PH_LO  = 2'd2;

    logic                 r_load_q;
    logic [1:0]           r_phase;
    logic [1:0]           w_phase_next;
    logic [ADDR_BITS-1:0] r_wr_addr;
    logic                 r_hold_hi;
    logic [3:0]           r_hold_mid;
    logic                 r_word_written;
    logic                 r_prog_full;
    logic                 r_format_err;

    logic                 w_session_start;
    logic                 w_accept;
    logic                 w_take_hi;
    logic                 w_take_mid;
    logic                 w_commit;
    logic [WORD_BITS-1:0] w_commit_word;
    logic [WORD_BITS-1:0] w_words [DEPTH];

    // The start cycle swallows any strobe so a session always begins at phase 0.
    assign w_session_start = load_mode & ~r_load_q;
    assign w_accept        = strobe & load_mode & ~w_session_start;
    assign w_commit_word   = WORD_BITS'({r_hold_hi, r_hold_mid, nibble});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase <= PH_HI;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Leaving load mode drops any partial word; an illegal phase recovers to 0.
    always_comb begin
        w_phase_next = r_phase;
        if (w_session_start || !load_mode) begin
            w_phase_next = PH_HI;
        end else begin
            case (r_phase)
                PH_HI:   if (w_accept) w_phase_next = PH_MID;
                PH_MID:  if (w_accept) w_phase_next = PH_LO;
                PH_LO:   if (w_accept) w_phase_next = PH_HI;
                default: w_phase_next = PH_HI;
            endcase
        end
    end

    always_comb begin
        w_take_hi  = 1'b0;
        w_take_mid = 1'b0;
        w_commit   = 1'b0;
        if (w_accept) begin
            case (r_phase)
                PH_HI:   w_take_hi  = 1'b1;
                PH_MID:  w_take_mid = 1'b1;
                PH_LO:   w_commit   = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_load_q       <= 1'b0;
            r_wr_addr      <= '0;
            r_hold_hi      <= 1'b0;
            r_hold_mid     <= 4'd0;
            r_word_written <= 1'b0;
            r_prog_full    <= 1'b0;
            r_format_err   <= 1'b0;
        end else begin
            r_load_q       <= load_mode;
            r_word_written <= w_commit;
            if (w_session_start) begin
                r_wr_addr    <= '0;
                r_prog_full  <= 1'b0;
                r_format_err <= 1'b0;
            end else begin
                if (w_take_hi) begin
                    r_hold_hi <= nibble[0];
                    if (nibble[3:1] != 3'd0) begin
                        r_format_err <= 1'b1;
                    end
                end
                if (w_take_mid) begin
                    r_hold_mid <= nibble;
                end
                if (w_commit) begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                    if (r_wr_addr == LAST_ADDR) begin
                        r_prog_full <= 1'b1;
                    end
                end
            end
        end
    end

    // One register per word so reset can clear the whole store at once.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WORD_BITS-1:0] r_word;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_word <= '0;
                end else if (w_commit && (r_wr_addr == ADDR_BITS'(gi))) begin
                    r_word <= w_commit_word;
                end
            end
            assign w_words[gi] = r_word;
        end
    endgenerate

    assign statement    = w_words[pc];
    assign cpu_hold     = r_load_q;
    assign wr_addr      = r_wr_addr;
    assign phase        = r_phase;
    assign word_written = r_word_written;
    assign prog_full    = r_prog_full;
    assign format_err   = r_format_err;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: commits are checked by a queue-driven monitor,
// static state and program-store readback are checked inline.
module tb_program_loader;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_mode;
    logic       strobe;
    logic [3:0] nibble;
    logic [2:0] pc;
    logic [8:0] statement;
    logic       cpu_hold;
    logic [2:0] wr_addr;
    logic [1:0] phase;
    logic       word_written;
    logic       prog_full;
    logic       format_err;

    program_loader #(.ADDR_BITS(3), .WORD_BITS(9)) dut (
        .clock(clock), .reset(reset), .load_mode(load_mode), .strobe(strobe),
        .nibble(nibble), .pc(pc), .statement(statement), .cpu_hold(cpu_hold),
        .wr_addr(wr_addr), .phase(phase), .word_written(word_written),
        .prog_full(prog_full), .format_err(format_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] addr;
        logic       pf;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Words k = {1, k, ~k} for k = 0..7, worked out by hand.
    logic [8:0] fill_tbl [8] = '{9'h10F, 9'h11E, 9'h12D, 9'h13C, 9'h14B, 9'h15A, 9'h169, 9'h178};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [3:0] n);
        $display("[TB] strobe nibble=%h", n);
        strobe = 1'b1;
        nibble = n;
        tick();
        strobe = 1'b0;
        nibble = 4'h0;
        tick();
    endtask

    task automatic expect_commit(input logic [2:0] a, input logic pf, input logic fe);
        exp_t e;
        e.addr = a;
        e.pf   = pf;
        e.fe   = fe;
        exp_q.push_back(e);
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [8:0] e);
        pc = a;
        #1;
        chk(name, statement, e);
        tick();
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset && word_written) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_commit: got word_written=1 at wr_addr=%0d, expected none", wr_addr);
            end else begin
                e = exp_q.pop_front();
                $display("[TB] commit seen, next wr_addr=%0d prog_full=%0b format_err=%0b", wr_addr, prog_full, format_err);
                chk("commit_wr_addr", wr_addr, e.addr);
                chk("commit_prog_full", prog_full, e.pf);
                chk("commit_format_err", format_err, e.fe);
            end
        end
    end

    initial begin
        reset = 1'b1; load_mode = 1'b0; strobe = 1'b0; nibble = 4'h0; pc = 3'd0;
        repeat (3) tick();
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_phase", phase, 0);
        chk("rst_word_written", word_written, 0);
        chk("rst_prog_full", prog_full, 0);
        chk("rst_format_err", format_err, 0);
        reset = 1'b0;
        tick();

        // Single word 1,3,2 -> 9'h132 at address 0.
        load_mode = 1'b1;
        tick();
        chk("start_cpu_hold", cpu_hold, 1);
        send(4'h1);
        chk("w0_phase1", phase, 1);
        send(4'h3);
        chk("w0_phase2", phase, 2);
        expect_commit(3'd1, 1'b0, 1'b0);
        send(4'h2);
        chk("w0_phase0", phase, 0);
        chk("w0_wr_addr", wr_addr, 1);
        rd("w0_read", 3'd0, 9'h132);

        // Fresh session, fill all 8 words.
        load_mode = 1'b0;
        tick();
        load_mode = 1'b1;
        tick();
        chk("fill_start_wr_addr", wr_addr, 0);
        for (int k = 0; k < 8; k++) begin
            logic [3:0] kn;
            kn = 4'(k);
            send(4'h1);
            send(kn);
            expect_commit(3'(k + 1), (k == 7), 1'b0);
            send(~kn);
        end
        chk("fill_prog_full", prog_full, 1);
        chk("fill_wr_addr", wr_addr, 0);
        for (int k = 0; k < 8; k++) begin
            rd($sformatf("fill_read%0d", k), 3'(k), fill_tbl[k]);
        end

        // Partial word, then drop load_mode with a strobe on the falling cycle.
        send(4'h1);
        send(4'h5);
        chk("abort_phase2", phase, 2);
        load_mode = 1'b0;
        strobe = 1'b1;
        nibble = 4'h7;
        #1;
        chk("abort_hold_before", cpu_hold, 1);
        tick();
        strobe = 1'b0;
        nibble = 4'h0;
        chk("abort_phase", phase, 0);
        chk("abort_wr_addr", wr_addr, 0);
        chk("abort_hold_after", cpu_hold, 0);
        chk("abort_prog_full_sticky", prog_full, 1);
        rd("abort_mem0", 3'd0, 9'h10F);

        // Format error: first nibble A -> word {0,5,6}.
        load_mode = 1'b1;
        tick();
        chk("fe_start_prog_full", prog_full, 0);
        chk("fe_start_format_err", format_err, 0);
        send(4'hA);
        chk("fe_set", format_err, 1);
        send(4'h5);
        expect_commit(3'd1, 1'b0, 1'b1);
        send(4'h6);
        rd("fe_read", 3'd0, 9'h056);

        // Strobe while idle is ignored.
        load_mode = 1'b0;
        tick();
        tick();
        send(4'h1);
        chk("idle_phase", phase, 0);
        chk("idle_wr_addr", wr_addr, 1);
        chk("idle_format_err", format_err, 1);

        // New session clears format_err; commit to the address being read.
        load_mode = 1'b1;
        tick();
        chk("fe_cleared", format_err, 0);
        chk("s2_wr_addr", wr_addr, 0);
        pc = 3'd0;
        send(4'h1);
        send(4'hF);
        expect_commit(3'd1, 1'b0, 1'b0);
        strobe = 1'b1;
        nibble = 4'hF;
        #1;
        chk("same_addr_old", statement, 9'h056);
        @(posedge clock);
        #1;
        strobe = 1'b0;
        nibble = 4'h0;
        chk("same_addr_new", statement, 9'h1FF);
        tick();

        // Reset between 2nd and 3rd nibble.
        send(4'h3);
        send(4'h4);
        chk("mid_phase2", phase, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_cpu_hold", cpu_hold, 0);
        chk("arst_wr_addr", wr_addr, 0);
        chk("arst_phase", phase, 0);
        chk("arst_word_written", word_written, 0);
        chk("arst_prog_full", prog_full, 0);
        chk("arst_format_err", format_err, 0);
        for (int k = 0; k < 8; k++) begin
            pc = 3'(k);
            #1;
            chk($sformatf("arst_read%0d", k), statement, 9'h000);
        end
        load_mode = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_hold", cpu_hold, 0);
        chk("post_rst_phase", phase, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 3, program address width (DEPTH = 2**ADDR_BITS words).
REQ-002 SHALL have parameter WORD_BITS, default 9, instruction word width: 1 MSB, 4-bit field, 4-bit arg.
REQ-003 Clocking SHALL be one clock; reset SHALL be asynchronous, active-high.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 load_mode  input  1  high = loader owns the program store and the CPU is held.
REQ-007 strobe  input  1  one-cycle pulse, already synchronous to clock: accept one nibble.
REQ-008 nibble  input  4  data nibble sampled on strobe.
REQ-009 pc  input  ADDR_BITS  CPU program counter (read address).
REQ-010 statement  output  WORD_BITS  instruction word at pc, feeding the CPU decoder.
REQ-011 cpu_hold  output  1  high = CPU step must be ignored.
REQ-012 wr_addr  output  ADDR_BITS  next word address to be written.
REQ-013 phase  output  2  nibble position within the current word (0, 1 or 2).
REQ-014 word_written  output  1  one-cycle pulse on each committed word.
REQ-015 prog_full  output  1  sticky: the last address has been written in this load session.
REQ-016 format_err  output  1  sticky: nonzero nibble[3:1] seen at phase 0 in this load session.

Function
REQ-017 Store SHALL be DEPTH x WORD_BITS registers; statement SHALL equal mem[pc] combinationally, zero latency.
REQ-018 On a write cycle with wr_addr == pc, statement SHALL show the old word until the next clock edge.
REQ-019 cpu_hold SHALL equal the load_mode registered once (one-cycle delay).
REQ-020 The load_mode rising edge (detected against the registered copy) SHALL set wr_addr=0 and phase=0, and clear prog_full and format_err; memory SHALL be unchanged.
REQ-021 A strobe SHALL be ignored while load_mode=0 or on the session-start cycle.
REQ-022 phase 0 + strobe: hold_hi <= nibble[0]; if nibble[3:1]!=0, format_err <= 1; phase <= 1.
REQ-023 phase 1 + strobe: hold_mid <= nibble; phase <= 2.
REQ-024 phase 2 + strobe: mem[wr_addr] <= {hold_hi, hold_mid, nibble}; word_written=1 next cycle; wr_addr <= wr_addr+1 modulo DEPTH; phase <= 0.
REQ-025 A commit with wr_addr == DEPTH-1 SHALL set prog_full, and wr_addr SHALL wrap to 0; further words overwrite from address 0.
REQ-026 load_mode falling with phase != 0 SHALL discard the partial word: phase <= 0, no write, and wr_addr holds.
REQ-027 A strobe on the same cycle load_mode falls SHALL be ignored.
REQ-028 phase SHALL never take the value 3; if it does, it SHALL recover to 0 on the next clock.

Reset
REQ-029 reset SHALL immediately clear all memory words to 0, and set wr_addr=0, phase=0, hold regs=0, cpu_hold=0, word_written=0, prog_full=0, format_err=0.
REQ-030 reset asserted mid-word or mid-session SHALL abandon the load; after release, a new load_mode rise is needed to start a session.

Verification
REQ-031 Raise load_mode, then strobes 1,3,2 -> mem[0]=9'h132, word_written pulses once, wr_addr=1, phase=0; pc=0 gives statement=9'h132.
REQ-032 24 strobes (8 words, word k = {1,k,~k}) -> prog_full=1 after the 8th commit, wr_addr=0, and each pc reads back the matching word.
REQ-033 Strobes 1,5 then drop load_mode -> no write, phase=0, wr_addr unchanged, cpu_hold falls one cycle later.
REQ-034 First nibble 4'hA -> format_err=1, and word is {0,mid,lo}; a new load_mode rise clears format_err.
REQ-035 Assert reset between the 2nd and 3rd nibble -> all outputs 0, and every statement reads 9'h000.
REQ-036 strobe with load_mode=0 -> no state change; commit to the address equal to pc -> old word that cycle, new word the next.
